// File: rtl/bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// bcd_updown_counter
//
// Packed-BCD up/down counter used as the stopwatch time base. The count feeds
// the 7-segment display path directly, so it is kept in BCD at all times and
// never holds a digit above 9.
//
// Parameters:
//   DIGITS      number of BCD digits in the count (1..8)
//   LOAD_DIGITS number of upper digits written by LOAD (1..DIGITS)
//   WRAP        1 = wrap around at the limits, 0 = saturate at the limits
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active-high
//   tick    in   count enable, qualifies UP and DOWN only
//   op      in   [2:0] operation select:
//                  000 HOLD, 001 UP, 010 DOWN, 011 CLEAR, 100 PRESET,
//                  101 LOAD, 110/111 HOLD
//   ext     in   [4*LOAD_DIGITS-1:0] packed-BCD preload for the upper digits
//   count   out  [4*DIGITS-1:0] packed-BCD count, digit 0 in bits [3:0]
//   at_zero out  count is all zeros
//   at_max  out  count is all nines
//   tc      out  one-cycle pulse after UP&tick at all-nines or DOWN&tick at
//                zero (fires in both WRAP modes)
// ----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int DIGITS      = 4,
    parameter int LOAD_DIGITS = 2,
    parameter int WRAP        = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [2:0]                 op,
    input  logic [4*LOAD_DIGITS-1:0]   ext,
    output logic [4*DIGITS-1:0]        count,
    output logic                       at_zero,
    output logic                       at_max,
    output logic                       tc
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_UP     = 3'b001;
    localparam logic [2:0] OP_DOWN   = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_PRESET = 3'b100;
    localparam logic [2:0] OP_LOAD   = 3'b101;

    logic [W-1:0] count_q;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] load_val;
    logic         carry;
    logic         borrow;
    logic         inc_ovf;
    logic         dec_unf;

    // Clamp a preload digit into the BCD range so a bad ext value can never
    // put a non-BCD digit into the count.
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Decimal increment/decrement as a per-digit ripple. A digit only moves
    // while the carry (borrow) is still live; once a digit absorbs it, all
    // higher digits hold. A carry (borrow) surviving the top digit means the
    // count was at all-nines (zero), and the natural ripple result is already
    // the wrapped value.
    always_comb begin
        inc_val = count_q;
        dec_val = count_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        inc_ovf = carry;
        dec_unf = borrow;
    end

    // LOAD image: ext fills the top LOAD_DIGITS digits, the rest are zero.
    // Built digit by digit so LOAD_DIGITS == DIGITS needs no zero-width field.
    always_comb begin
        load_val = '0;
        for (int i = 0; i < LOAD_DIGITS; i++) begin
            load_val[4*(DIGITS-LOAD_DIGITS+i) +: 4] = clamp9(ext[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc      <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (op)
                OP_UP: begin
                    if (tick) begin
                        if (inc_ovf) begin
                            tc <= 1'b1;
                            if (WRAP != 0) count_q <= inc_val;
                        end else begin
                            count_q <= inc_val;
                        end
                    end
                end
                OP_DOWN: begin
                    if (tick) begin
                        if (dec_unf) begin
                            tc <= 1'b1;
                            if (WRAP != 0) count_q <= dec_val;
                        end else begin
                            count_q <= dec_val;
                        end
                    end
                end
                OP_CLEAR:  count_q <= '0;
                OP_PRESET: count_q <= ALL_NINES;
                OP_LOAD:   count_q <= load_val;
                OP_HOLD:   count_q <= count_q;
                default:   count_q <= count_q;
            endcase
        end
    end

    assign count   = count_q;
    assign at_zero = (count_q == '0);
    assign at_max  = (count_q == ALL_NINES);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Drives a WRAP=1 and a WRAP=0 instance (DIGITS=4, LOAD_DIGITS=2) with the
// same stimulus. Directed phases use hand-computed values; the soak phase
// compares both instances against a decimal integer model through an
// expected-value queue.
// ----------------------------------------------------------------------------
module tb_bcd_updown_counter;

    localparam int DIGITS      = 4;
    localparam int LOAD_DIGITS = 2;
    localparam int W           = 4 * DIGITS;
    localparam int SOAK_CYCLES = 10000;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_UP     = 3'b001;
    localparam logic [2:0] OP_DOWN   = 3'b010;
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_PRESET = 3'b100;
    localparam logic [2:0] OP_LOAD   = 3'b101;

    logic                     clk;
    logic                     rst;
    logic                     tick;
    logic [2:0]               op;
    logic [4*LOAD_DIGITS-1:0] ext;

    logic [W-1:0] count_w, count_s;
    logic         at_zero_w, at_zero_s;
    logic         at_max_w, at_max_s;
    logic         tc_w, tc_s;

    int n_checks;
    int n_errors;

    // expected {count, at_zero, at_max, tc} entries, wrap then sat per cycle
    logic [W+2:0] exp_q[$];

    bcd_updown_counter #(.DIGITS(DIGITS), .LOAD_DIGITS(LOAD_DIGITS), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .op(op), .ext(ext),
        .count(count_w), .at_zero(at_zero_w), .at_max(at_max_w), .tc(tc_w)
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .LOAD_DIGITS(LOAD_DIGITS), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .op(op), .ext(ext),
        .count(count_s), .at_zero(at_zero_s), .at_max(at_max_s), .tc(tc_s)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks both instances' count and tc plus the flag decode.
    task automatic expect_both(input string tag, input logic [W-1:0] cw, input logic [W-1:0] cs,
                               input logic tw, input logic ts);
        check_eq({tag, " wrap count"}, 32'(count_w), 32'(cw));
        check_eq({tag, " sat count"},  32'(count_s), 32'(cs));
        check_eq({tag, " wrap tc"},    32'(tc_w), 32'(tw));
        check_eq({tag, " sat tc"},     32'(tc_s), 32'(ts));
        check_eq({tag, " wrap flags"}, 32'({at_zero_w, at_max_w}),
                 32'({cw == 16'h0000, cw == 16'h9999}));
        check_eq({tag, " sat flags"},  32'({at_zero_s, at_max_s}),
                 32'({cs == 16'h0000, cs == 16'h9999}));
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 1 ns after the
    // rising edge that consumed them.
    task automatic drive(input logic [2:0] o, input logic t, input logic [7:0] e);
        @(negedge clk);
        op   = o;
        tick = t;
        ext  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_n(input logic [2:0] o, input logic t, input int n);
        for (int i = 0; i < n; i++) drive(o, t, 8'h00);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_dig(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    task automatic model_step(input int wrap, input logic [2:0] o, input logic t,
                              input logic [7:0] e, inout int v, output logic tcv);
        tcv = 1'b0;
        case (o)
            OP_UP: if (t) begin
                if (v == 9999) begin
                    tcv = 1'b1;
                    v = (wrap != 0) ? 0 : 9999;
                end else v = v + 1;
            end
            OP_DOWN: if (t) begin
                if (v == 0) begin
                    tcv = 1'b1;
                    v = (wrap != 0) ? 9999 : 0;
                end else v = v - 1;
            end
            OP_CLEAR:  v = 0;
            OP_PRESET: v = 9999;
            OP_LOAD:   v = (clamp_dig(e[7:4]) * 10 + clamp_dig(e[3:0])) * 100;
            default:   v = v;
        endcase
    endtask

    // ---------------- stimulus ----------------
    int          v_w, v_s;
    logic        t_w, t_s;
    logic [2:0]  r_op;
    logic        r_tick;
    logic [7:0]  r_ext;
    logic [W+2:0] e_item;
    logic [W-1:0] bcd_w, bcd_s;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        op   = OP_HOLD;
        tick = 1'b0;
        ext  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        expect_both("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1. reset mid-count at 0x0347, then hold
        drive(OP_LOAD, 1'b0, 8'h03);
        drive_n(OP_UP, 1'b1, 47);
        expect_both("pre-rst", 16'h0347, 16'h0347, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        expect_both("async rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        op  = OP_HOLD;
        rst = 1'b0;
        drive_n(OP_HOLD, 1'b1, 5);
        expect_both("hold 5", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // 2. up with carry chain
        drive(OP_LOAD, 1'b0, 8'h00);
        drive_n(OP_UP, 1'b1, 98);
        expect_both("up 98", 16'h0098, 16'h0098, 1'b0, 1'b0);
        drive(OP_UP, 1'b1, 8'h00);
        expect_both("up 99", 16'h0099, 16'h0099, 1'b0, 1'b0);
        drive(OP_UP, 1'b1, 8'h00);
        expect_both("up carry", 16'h0100, 16'h0100, 1'b0, 1'b0);
        drive_n(OP_UP, 1'b0, 3);
        expect_both("up no tick", 16'h0100, 16'h0100, 1'b0, 1'b0);
        drive(OP_LOAD, 1'b0, 8'h09);
        drive_n(OP_UP, 1'b1, 99);
        expect_both("up 0999", 16'h0999, 16'h0999, 1'b0, 1'b0);
        drive(OP_UP, 1'b1, 8'h00);
        expect_both("up 1000", 16'h1000, 16'h1000, 1'b0, 1'b0);

        // 3. wrap vs saturate at all-nines
        drive(OP_PRESET, 1'b0, 8'h00);
        expect_both("preset", 16'h9999, 16'h9999, 1'b0, 1'b0);
        drive(OP_UP, 1'b1, 8'h00);
        expect_both("up limit", 16'h0000, 16'h9999, 1'b1, 1'b1);
        drive(OP_HOLD, 1'b1, 8'h00);
        expect_both("tc drop up", 16'h0000, 16'h9999, 1'b0, 1'b0);

        // 4. down with borrow, and limit at zero
        drive(OP_LOAD, 1'b0, 8'h12);
        expect_both("load 12", 16'h1200, 16'h1200, 1'b0, 1'b0);
        drive(OP_DOWN, 1'b1, 8'h00);
        expect_both("down 1199", 16'h1199, 16'h1199, 1'b0, 1'b0);
        drive(OP_DOWN, 1'b1, 8'h00);
        expect_both("down 1198", 16'h1198, 16'h1198, 1'b0, 1'b0);
        drive(OP_DOWN, 1'b0, 8'h00);
        expect_both("down no tick", 16'h1198, 16'h1198, 1'b0, 1'b0);
        drive(OP_CLEAR, 1'b1, 8'h00);
        drive(OP_DOWN, 1'b1, 8'h00);
        expect_both("down limit", 16'h9999, 16'h0000, 1'b1, 1'b1);
        drive(OP_HOLD, 1'b0, 8'h00);
        expect_both("tc drop dn", 16'h9999, 16'h0000, 1'b0, 1'b0);

        // 5. load sanitising, preset, clear
        drive(OP_LOAD, 1'b1, 8'hA5);
        expect_both("load A5", 16'h9500, 16'h9500, 1'b0, 1'b0);
        drive(OP_LOAD, 1'b0, 8'h3F);
        expect_both("load 3F", 16'h3900, 16'h3900, 1'b0, 1'b0);
        drive(OP_PRESET, 1'b0, 8'h00);
        expect_both("preset2", 16'h9999, 16'h9999, 1'b0, 1'b0);
        drive(OP_CLEAR, 1'b0, 8'h00);
        expect_both("clear", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // 6. undefined ops hold
        drive(OP_LOAD, 1'b0, 8'h04);
        drive_n(OP_UP, 1'b1, 20);
        expect_both("pre-undef", 16'h0420, 16'h0420, 1'b0, 1'b0);
        drive(3'b110, 1'b1, 8'h77);
        expect_both("op 110", 16'h0420, 16'h0420, 1'b0, 1'b0);
        drive(3'b111, 1'b1, 8'h77);
        expect_both("op 111", 16'h0420, 16'h0420, 1'b0, 1'b0);

        // soak against the decimal model
        drive(OP_CLEAR, 1'b0, 8'h00);
        v_w = 0;
        v_s = 0;
        for (int c = 0; c < SOAK_CYCLES; c++) begin
            r_op   = 3'($urandom_range(0, 7));
            // favour counting so the limits are reached from preset/clear
            if ($urandom_range(0, 3) != 0) r_op = 3'($urandom_range(1, 2));
            r_tick = 1'($urandom_range(0, 1));
            r_ext  = 8'($urandom_range(0, 255));
            model_step(1, r_op, r_tick, r_ext, v_w, t_w);
            model_step(0, r_op, r_tick, r_ext, v_s, t_s);
            bcd_w = to_bcd(v_w);
            bcd_s = to_bcd(v_s);
            exp_q.push_back({bcd_w, v_w == 0, v_w == 9999, t_w});
            exp_q.push_back({bcd_s, v_s == 0, v_s == 9999, t_s});
            drive(r_op, r_tick, r_ext);
            e_item = exp_q.pop_front();
            check_eq("soak wrap", 32'({count_w, at_zero_w, at_max_w, tc_w}), 32'(e_item));
            e_item = exp_q.pop_front();
            check_eq("soak sat",  32'({count_s, at_zero_s, at_max_s, tc_s}), 32'(e_item));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised BCD up/down counter: the next-generation time base for the stopwatch datapath. Replaces the fixed 14-bit binary counter with a DIGITS-wide packed-BCD count that feeds the 7-segment display path directly, with no binary-to-BCD conversion. Adds a count-enable tick, a selectable wrap or saturate mode, a BCD preload of the upper digits, terminal flags and a terminal-count pulse. Sits between the control FSM, which drives op and tick, and the display decoder.

Parameters:
DIGITS, 4, number of BCD digits in the count (1..8)
LOAD_DIGITS, 2, number of upper digits written by the LOAD op (1..DIGITS)
WRAP, 1, 1 = wrap around at the limits; 0 = saturate at the limits

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
tick  in  1  count enable; qualifies UP/DOWN only
op  in  3  operation select, sampled every cycle
ext  in  4*LOAD_DIGITS  packed-BCD preload value for the upper digits
count  out  4*DIGITS  packed-BCD count; digit 0 is bits [3:0] (least significant)
at_zero  out  1  count equals all zeros
at_max  out  1  count equals all nines
tc  out  1  one-cycle terminal-count pulse

Behaviour:
- Reset (async, rst=1): count=0, tc=0, so at_zero=1 and at_max=0. Reset asserted mid-operation overrides everything immediately. The first update after rst deasserts happens on the next rising clk edge.
- op decode; the result is visible on count one cycle after sampling:
  - 000 HOLD: count unchanged.
  - 001 UP: if tick=1, count+1 in decimal; if tick=0, hold.
  - 010 DOWN: if tick=1, count-1 in decimal; if tick=0, hold.
  - 011 CLEAR: count=0. Ignores tick.
  - 100 PRESET: all digits set to 9. Ignores tick.
  - 101 LOAD: upper LOAD_DIGITS digits take ext, lower DIGITS-LOAD_DIGITS digits take 0. Ignores tick.
  - 110, 111: HOLD. Both are defined; there is no X or -1 assignment.
- BCD arithmetic, per digit ripple:
  - UP: a digit at 9 becomes 0 and carries; otherwise it increments, and higher digits hold.
  - DOWN: a digit at 0 becomes 9 and borrows; otherwise it decrements.
  - The full carry/borrow chain resolves within one cycle.
- Limits:
  - UP at all-nines: WRAP=1 gives 0; WRAP=0 holds all-nines.
  - DOWN at zero: WRAP=1 gives all-nines; WRAP=0 holds 0.
- tc: registered. It is 1 for exactly one cycle, the cycle after an edge where UP&tick occurred at all-nines or DOWN&tick occurred at zero. It fires in both WRAP modes. Otherwise tc=0.
- at_zero and at_max: combinational decode of the registered count. They change in the same cycle as count, with no extra latency.
- ext sanitising: any ext digit >9 loads as 9, per digit. Other digits are unaffected.
- LOAD with LOAD_DIGITS=DIGITS: the whole count comes from ext and there are no zeroed digits.
- count never holds a non-BCD digit under any op sequence.
- Op changes take effect on the very next edge. No op is pipelined or queued.

Test Plan:
1. Reset and hold: assert rst mid-count at 0x0347 -> count=0x0000, at_zero=1, tc=0 immediately. Release rst, then op=000 for 5 cycles -> count stays 0x0000.
2. Up with carry chain: preset via LOAD ext=0x00, then op=001 with tick every cycle starting from 0x0098 -> sequence 0x0099, 0x0100. With tick=0 for 3 cycles -> holds 0x0100.
3. Wrap vs saturate, WRAP=1 and WRAP=0 instances:
   - From all-nines 0x9999, op=001 tick=1 -> WRAP=1 gives 0x0000; WRAP=0 gives 0x9999.
   - In both instances tc=1 for exactly the next cycle, and at_max/at_zero track count.
4. Down with borrow: LOAD ext=0x12 (DIGITS=4) -> 0x1200. Then op=010 tick=1 -> 0x1199, 0x1198.
   - Separately, from 0x0000 with WRAP=1 -> 0x9999 and tc pulses.
5. LOAD sanitising: ext=0xA5 -> count=0x9500.
   - PRESET gives 0x9999 and at_max=1.
   - CLEAR with tick=0 gives 0x0000.
6. Undefined ops: op=110 and then op=111 from 0x0420 -> count stays 0x0420, tc=0.
   - Random op/tick/ext soak of 10k cycles against a decimal reference model -> no mismatch and no non-BCD digit.
